// File: rtl/modbus_rtu_tx_control_if.sv
// Request, data-fetch and UART/RS-485 signals of the Modbus RTU request framer.
// The master side is the host plus UART; the slave side is the framer.
interface modbus_rtu_tx_control_if;
    logic        start;
    logic        write_en;
    logic [7:0]  adr;
    logic [15:0] reg_addr;
    logic [7:0]  n_regs;
    logic [15:0] data_in;
    logic        data_req;
    logic [7:0]  data_idx;
    logic        tx_busy;
    logic [7:0]  byte_out;
    logic        byte_strb;
    logic        DE;
    logic        busy;
    logic        done;
    logic        req_error;

    modport master (
        output start, write_en, adr, reg_addr, n_regs, data_in, tx_busy,
        input  data_req, data_idx, byte_out, byte_strb, DE, busy, done, req_error
    );

    modport slave (
        input  start, write_en, adr, reg_addr, n_regs, data_in, tx_busy,
        output data_req, data_idx, byte_out, byte_strb, DE, busy, done, req_error
    );
endinterface

// File: rtl/modbus_rtu_tx_control.sv
// Modbus RTU master request framer: builds 0x03 / 0x10 frames with CRC-16/Modbus,
// paces bytes to the UART and drives the RS-485 driver enable with lead/tail guard times.
module modbus_rtu_tx_control #(
    parameter int unsigned clk_freq_MHz   = 80,
    parameter int unsigned frame_gap_us   = 2000,
    parameter int unsigned de_lead_cycles = 16,
    parameter int unsigned de_tail_cycles = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    modbus_rtu_tx_control_if.slave  bus
);

    localparam int unsigned GAP_W = 20;
    localparam int unsigned TMR_W = 16;
    localparam int unsigned CNT_W = 9;

    localparam logic [GAP_W-1:0] GAP_COUNT = GAP_W'(clk_freq_MHz * frame_gap_us);
    localparam logic [TMR_W-1:0] LEAD_INIT = TMR_W'(de_lead_cycles);
    // TAIL is entered one cycle after the last byte completes, so it runs one cycle short.
    localparam logic [TMR_W-1:0] TAIL_INIT = TMR_W'((de_tail_cycles > 0) ? de_tail_cycles - 1 : 0);
    localparam logic [7:0]       MAX_RD    = 8'd125;
    localparam logic [7:0]       MAX_WR    = 8'd123;

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_LEAD, S_LOAD, S_FETCH, S_SEND, S_WAIT, S_TAIL
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               wr_q, wr_d;
    logic [7:0]         adr_q, adr_d;
    logic [15:0]        reg_q, reg_d;
    logic [7:0]         n_q, n_d;
    logic [15:0]        word_q, word_d;
    logic [15:0]        crc_q, crc_d;
    logic               wait_first_q, wait_first_d;
    logic [7:0]         data_idx_q, data_idx_d;
    logic [7:0]         byte_out_q, byte_out_d;
    logic               byte_strb_q, byte_strb_d;
    logic               de_q, de_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               req_error_q, req_error_d;
    logic               data_req_q, data_req_d;

    logic [CNT_W-1:0]   frame_len;
    logic [CNT_W-1:0]   crc_lo_idx;
    logic               in_data;
    logic               is_data_hi;
    logic               is_data_lo;
    logic               is_crc;
    logic               start_legal;
    logic [7:0]         sel_byte;

    // One byte of CRC-16/Modbus (reflected polynomial 0xA001).
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] r;
        r = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign bus.byte_out  = byte_out_q;
    assign bus.byte_strb = byte_strb_q;
    assign bus.DE        = de_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.req_error = req_error_q;
    assign bus.data_req  = data_req_q;
    assign bus.data_idx  = data_idx_q;

    // Byte classification for the current frame position.
    always_comb begin
        frame_len   = wr_q ? (CNT_W'(9) + {n_q, 1'b0}) : CNT_W'(8);
        crc_lo_idx  = frame_len - CNT_W'(2);
        in_data     = wr_q && (byte_cnt_q >= CNT_W'(7)) && (byte_cnt_q < crc_lo_idx);
        is_data_hi  = in_data && byte_cnt_q[0];
        is_data_lo  = in_data && !byte_cnt_q[0];
        is_crc      = (byte_cnt_q >= crc_lo_idx);
        start_legal = (bus.n_regs != 8'd0) &&
                      (bus.write_en ? (bus.n_regs <= MAX_WR) : (bus.n_regs <= MAX_RD));
    end

    // Header / data_lo / CRC byte mux; data_hi bytes come straight from data_in in FETCH.
    always_comb begin
        sel_byte = 8'h00;
        if (byte_cnt_q == crc_lo_idx) begin
            sel_byte = crc_q[7:0];
        end else if (byte_cnt_q > crc_lo_idx) begin
            sel_byte = crc_q[15:8];
        end else if (is_data_lo) begin
            sel_byte = word_q[7:0];
        end else begin
            case (byte_cnt_q)
                CNT_W'(0): sel_byte = adr_q;
                CNT_W'(1): sel_byte = wr_q ? 8'h10 : 8'h03;
                CNT_W'(2): sel_byte = reg_q[15:8];
                CNT_W'(3): sel_byte = reg_q[7:0];
                CNT_W'(4): sel_byte = 8'h00;
                CNT_W'(5): sel_byte = n_q;
                CNT_W'(6): sel_byte = {n_q[6:0], 1'b0};
                default:   sel_byte = 8'h00;
            endcase
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = (gap_cnt_q < GAP_COUNT) ? (gap_cnt_q + GAP_W'(1)) : gap_cnt_q;
        timer_d      = timer_q;
        byte_cnt_d   = byte_cnt_q;
        wr_d         = wr_q;
        adr_d        = adr_q;
        reg_d        = reg_q;
        n_d          = n_q;
        word_d       = word_q;
        crc_d        = crc_q;
        wait_first_d = wait_first_q;
        data_idx_d   = data_idx_q;
        byte_out_d   = byte_out_q;
        byte_strb_d  = 1'b0;
        de_d         = de_q;
        done_d       = 1'b0;
        req_error_d  = 1'b0;
        data_req_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (start_legal) begin
                        wr_d       = bus.write_en;
                        adr_d      = bus.adr;
                        reg_d      = bus.reg_addr;
                        n_d        = bus.n_regs;
                        byte_cnt_d = '0;
                        data_idx_d = '0;
                        crc_d      = 16'hFFFF;
                        state_d    = S_GAP;
                    end else begin
                        req_error_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q >= GAP_COUNT) begin
                    de_d    = 1'b1;
                    timer_d = LEAD_INIT;
                    state_d = S_LEAD;
                end
            end
            S_LEAD: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = S_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_LOAD: begin
                if (is_data_hi) begin
                    state_d = S_FETCH;
                end else begin
                    byte_out_d  = sel_byte;
                    byte_strb_d = 1'b1;
                    state_d     = S_SEND;
                end
            end
            S_FETCH: begin
                word_d      = bus.data_in;
                byte_out_d  = bus.data_in[15:8];
                byte_strb_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (!is_crc) begin
                    crc_d = crc_step(crc_q, byte_out_q);
                end
                if (is_data_lo) begin
                    data_idx_d = data_idx_q + 8'd1;
                end
                byte_cnt_d   = byte_cnt_q + CNT_W'(1);
                wait_first_d = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // The UART raises tx_busy up to one cycle late, so the first WAIT cycle is blind.
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!bus.tx_busy) begin
                    if (byte_cnt_q == frame_len) begin
                        timer_d = TAIL_INIT;
                        state_d = S_TAIL;
                    end else begin
                        data_req_d = is_data_hi;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_TAIL: begin
                if (timer_q <= TMR_W'(1)) begin
                    de_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (de_q && !de_d) begin
            gap_cnt_d = '0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; the silence counter starts saturated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= GAP_COUNT;
            timer_q      <= '0;
            byte_cnt_q   <= '0;
            wr_q         <= 1'b0;
            adr_q        <= '0;
            reg_q        <= '0;
            n_q          <= '0;
            word_q       <= '0;
            crc_q        <= 16'hFFFF;
            wait_first_q <= 1'b0;
            data_idx_q   <= '0;
            byte_out_q   <= '0;
            byte_strb_q  <= 1'b0;
            de_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            req_error_q  <= 1'b0;
            data_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            timer_q      <= timer_d;
            byte_cnt_q   <= byte_cnt_d;
            wr_q         <= wr_d;
            adr_q        <= adr_d;
            reg_q        <= reg_d;
            n_q          <= n_d;
            word_q       <= word_d;
            crc_q        <= crc_d;
            wait_first_q <= wait_first_d;
            data_idx_q   <= data_idx_d;
            byte_out_q   <= byte_out_d;
            byte_strb_q  <= byte_strb_d;
            de_q         <= de_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            req_error_q  <= req_error_d;
            data_req_q   <= data_req_d;
        end
    end

endmodule

// File: tb/tb_modbus_rtu_tx_control.sv
// Scoreboard bench for modbus_rtu_tx_control: directed frames with hand-computed bytes,
// a UART busy model, a host data model and a negedge monitor that pops expectations.
module tb_modbus_rtu_tx_control;
    localparam int unsigned CLK_MHZ = 80;
    localparam int unsigned GAP_US  = 2;
    localparam int unsigned LEAD    = 16;
    localparam int unsigned TAIL    = 16;
    localparam int unsigned GAP_CYC = CLK_MHZ * GAP_US;
    localparam int unsigned PERIOD  = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    modbus_rtu_tx_control_if bus ();

    modbus_rtu_tx_control #(
        .clk_freq_MHz   (CLK_MHZ),
        .frame_gap_us   (GAP_US),
        .de_lead_cycles (LEAD),
        .de_tail_cycles (TAIL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int        n_checks = 0;
    int        n_pass   = 0;
    logic [7:0] exp_q[$];
    int        exp_idx_q[$];
    int        exp_err  = 0;
    int        strb_cnt = 0;
    int        done_cnt = 0;
    int        busy_min = 3;
    int        busy_max = 3;
    int        tail_st  = 0;
    int        tail_meas = -1;
    bit        first_pending = 1'b0;
    bit        de_prev = 1'b0;
    time       t_start, t_first, t_busy_low;
    logic [15:0] words [8];

    logic [7:0] frame_rd [8]  = '{8'h11, 8'h03, 8'h00, 8'h6B, 8'h00, 8'h03, 8'h76, 8'h87};
    logic [7:0] frame_wr [13] = '{8'h01, 8'h10, 8'h00, 8'h01, 8'h00, 8'h02, 8'h04,
                                  8'h00, 8'h0A, 8'h01, 8'h02, 8'h92, 8'h30};

    task automatic check(input string name, input longint act, input longint want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic push_rd();
        foreach (frame_rd[i]) exp_q.push_back(frame_rd[i]);
    endtask

    task automatic push_wr();
        foreach (frame_wr[i]) exp_q.push_back(frame_wr[i]);
        exp_idx_q.push_back(0);
        exp_idx_q.push_back(1);
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue(input bit wr, input logic [7:0] a, input logic [15:0] r,
                         input logic [7:0] n, input bit track);
        bus.write_en = wr; bus.adr = a; bus.reg_addr = r; bus.n_regs = n; bus.start = 1'b1;
        if (track) begin t_start = $time; first_pending = 1'b1; end
        @(negedge clk);
        bus.start = 1'b0;
        bus.write_en = ~wr; bus.adr = 8'hEE; bus.reg_addr = 16'hBEEF; bus.n_regs = 8'd7;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!bus.done && k < budget) begin @(negedge clk); k++; end
        check("done_within_budget", bus.done, 1);
    endtask

    task automatic close_frame(input string tag, input int d0, input int s0, input int nbytes);
        @(negedge clk); @(negedge clk);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_strobe_count"}, strb_cnt - s0, nbytes);
        check({tag, "_de_tail"}, tail_meas, TAIL);
        check({tag, "_bytes_drained"}, exp_q.size(), 0);
        check({tag, "_busy_after_done"}, bus.busy, 0);
    endtask

    // UART model: busy rises the cycle after a strobe and holds for a chosen length.
    initial begin : uart
        int n;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.byte_strb) begin
                n = int'($urandom_range(busy_max, busy_min));
                @(posedge clk); #1 bus.tx_busy = 1'b1;
                repeat (n) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    // Host model: presents the requested word one cycle after data_req.
    initial begin : host
        int idx;
        bus.data_in = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset_n && bus.data_req) begin
                idx = int'(bus.data_idx);
                @(posedge clk); #1 bus.data_in = words[3'(idx)];
            end
        end
    end

    initial begin : monitor
        logic [7:0] want_b;
        int want_i;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                tail_st = 0;
                de_prev = 1'b0;
                continue;
            end
            case (tail_st)
                1: if (bus.tx_busy) tail_st = 2;
                2: if (!bus.tx_busy) begin t_busy_low = $time; tail_st = 3; end
                3: if (!bus.DE) begin tail_meas = int'(($time - t_busy_low) / PERIOD); tail_st = 0; end
                default: ;
            endcase
            if (bus.byte_strb) begin
                strb_cnt++;
                if (first_pending) begin first_pending = 1'b0; t_first = $time; end
                check("no_strobe_while_busy", bus.tx_busy, 0);
                check("de_high_at_strobe", bus.DE, 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_byte: got 0x%02h expected no byte", bus.byte_out);
                end else begin
                    want_b = exp_q.pop_front();
                    check("byte_out", bus.byte_out, want_b);
                    if (exp_q.size() == 0) tail_st = 1;
                end
            end
            if (bus.data_req) begin
                if (exp_idx_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_data_req: got idx %0d expected none", bus.data_idx);
                end else begin
                    want_i = exp_idx_q.pop_front();
                    check("data_idx", bus.data_idx, want_i);
                end
            end
            if (bus.req_error) begin
                check("req_error_expected", (exp_err > 0) ? 1 : 0, 1);
                if (exp_err > 0) exp_err--;
            end
            if (bus.done) begin
                done_cnt++;
                check("de_low_at_done", bus.DE, 0);
                check("de_fell_at_done", de_prev, 1);
                check("busy_low_at_done", bus.busy, 0);
                check("frame_complete_at_done", exp_q.size(), 0);
            end
            de_prev = bus.DE;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d0, s0, k;
        bus.start = 1'b0; bus.write_en = 1'b0; bus.adr = 8'h00; bus.reg_addr = 16'h0000; bus.n_regs = 8'h00;
        words[0] = 16'h000A; words[1] = 16'h0102;
        for (int i = 2; i < 8; i++) words[i] = 16'hDEAD;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_byte_out", bus.byte_out, 0);
        check("rst_byte_strb", bus.byte_strb, 0);
        check("rst_de", bus.DE, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_req_error", bus.req_error, 0);
        check("rst_data_req", bus.data_req, 0);
        check("rst_data_idx", bus.data_idx, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Read, first frame after reset: no gap pending.
        d0 = done_cnt; s0 = strb_cnt; tail_meas = -1;
        push_rd();
        issue(1'b0, 8'h11, 16'h006B, 8'd3, 1'b1);
        check("rd_busy_after_start", bus.busy, 1);
        wait_done(3000);
        close_frame("rd", d0, s0, 8);
        check("rd_first_strobe_latency", (t_first - t_start) / PERIOD, LEAD + 3);

        // Write two registers.
        repeat (GAP_CYC + 5) @(negedge clk);
        d0 = done_cnt; s0 = strb_cnt; tail_meas = -1;
        push_wr();
        issue(1'b1, 8'h01, 16'h0001, 8'd2, 1'b0);
        wait_done(3000);
        close_frame("wr", d0, s0, 13);
        check("wr_all_data_req_seen", exp_idx_q.size(), 0);

        // Illegal counts are rejected without touching the bus.
        s0 = strb_cnt;
        exp_err++; issue(1'b1, 8'h01, 16'h0001, 8'd0, 1'b0);
        check("err_n0_busy", bus.busy, 0);
        repeat (4) @(negedge clk);
        exp_err++; issue(1'b0, 8'h01, 16'h0001, 8'd126, 1'b0);
        check("err_rd126_busy", bus.busy, 0);
        repeat (4) @(negedge clk);
        exp_err++; issue(1'b1, 8'h01, 16'h0001, 8'd124, 1'b0);
        repeat (30) @(negedge clk);
        check("err_all_reported", exp_err, 0);
        check("err_no_strobes", strb_cnt - s0, 0);
        check("err_de_low", bus.DE, 0);

        // Start during busy is dropped; start right after done waits out the gap.
        d0 = done_cnt; s0 = strb_cnt; tail_meas = -1;
        push_rd();
        issue(1'b0, 8'h11, 16'h006B, 8'd3, 1'b0);
        repeat (5) @(negedge clk);
        issue(1'b1, 8'h22, 16'h1234, 8'd2, 1'b0);
        wait_done(3000);
        tail_meas = -1;
        issue(1'b0, 8'h11, 16'h006B, 8'd3, 1'b1);
        push_rd();
        wait_done(3000);
        close_frame("b2b", d0 + 1, s0, 16);
        check_range("b2b_gap_latency", (t_first - t_start) / PERIOD, GAP_CYC + 17, GAP_CYC + 19);

        // Stretched UART busy.
        repeat (GAP_CYC + 5) @(negedge clk);
        busy_min = 10; busy_max = 2000;
        d0 = done_cnt; s0 = strb_cnt; tail_meas = -1;
        push_rd();
        issue(1'b0, 8'h11, 16'h006B, 8'd3, 1'b0);
        wait_done(40000);
        close_frame("slow", d0, s0, 8);
        busy_min = 3; busy_max = 3;

        // Reset after the fourth byte strobe, then a clean request.
        repeat (GAP_CYC + 5) @(negedge clk);
        d0 = done_cnt;
        push_wr();
        issue(1'b1, 8'h01, 16'h0001, 8'd2, 1'b0);
        k = 0;
        while (k < 4 && strb_cnt < 100000) begin
            @(negedge clk);
            if (bus.byte_strb) k++;
        end
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_de_low", bus.DE, 0);
        check("rst_mid_strb_low", bus.byte_strb, 0);
        check("rst_mid_busy_low", bus.busy, 0);
        exp_q.delete();
        exp_idx_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid_no_done", done_cnt - d0, 0);
        d0 = done_cnt; s0 = strb_cnt; tail_meas = -1;
        push_wr();
        issue(1'b1, 8'h01, 16'h0001, 8'd2, 1'b1);
        wait_done(3000);
        close_frame("post_rst", d0, s0, 13);
        check("post_rst_latency", (t_first - t_start) / PERIOD, LEAD + 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
